// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: state encodings and default sizes shared by count_monitor and its sampler.
package count_monitor_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/count_monitor_sampler.sv
// count_monitor_sampler: captures Q_IN; with COUNT_MONITOR_GLITCH_FILTER_EN a value is only qualified once two consecutive samples agree.
module count_monitor_sampler #(
    parameter int WIDTH = 4
) (
`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
    input  logic             CLOCK,
    input  logic             CLEAR,
`endif
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_ok
);

`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
    logic [WIDTH-1:0] prev;
    logic             prev_v;

    // Remember the previous edge's sample; prev_v blocks a false agreement right after reset.
    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            prev   <= '0;
            prev_v <= 1'b0;
        end else begin
            prev   <= q_in;
            prev_v <= 1'b1;
        end
    end

    assign sample    = q_in;
    assign sample_ok = prev_v && (q_in == prev);
`else
    assign sample    = q_in;
    assign sample_ok = 1'b1;
`endif

endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks a ripple count for +1/hold steps, counts wraps and pulses on compare matches.
// Optional glitch filter on Q_IN: define COUNT_MONITOR_GLITCH_FILTER_EN.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              CLOCK,
    input  logic              CLEAR,
    input  logic [WIDTH-1:0]  Q_IN,
    input  logic [WIDTH-1:0]  CMP,
    input  logic              ARM,
    input  logic              RESYNC,
    output logic [WIDTH-1:0]  COUNT_OUT,
    output logic              COUNT_VALID,
    output logic              WRAP,
    output logic [WRAP_W-1:0] WRAPS,
    output logic              MATCH,
    output logic              SEQ_ERR,
    output logic [1:0]        STATE
);

    state_t           state, nxt;
    logic [WIDTH-1:0] sample;
    logic             sample_ok;
    logic             hold, inc, legal_chg, wrap_d, match_d, load;

    count_monitor_sampler #(.WIDTH(WIDTH)) u_sampler (
`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
        .CLOCK     (CLOCK),
        .CLEAR     (CLEAR),
`endif
        .q_in      (Q_IN),
        .sample    (sample),
        .sample_ok (sample_ok)
    );

    assign STATE = state;

    // Step classification, next state and the event pulses they imply; RESYNC suppresses the step check.
    always_comb begin
        hold      = sample == COUNT_OUT;
        inc       = sample == WIDTH'(COUNT_OUT + 1'b1);
        legal_chg = state == ST_TRACK && !RESYNC && sample_ok && inc;
        wrap_d    = legal_chg && COUNT_OUT == '1;
        match_d   = legal_chg && ARM && sample == CMP;
        load      = sample_ok && (state == ST_SYNC || !RESYNC);
        nxt       = state == ST_SYNC ? (sample_ok ? ST_TRACK : ST_SYNC)
                  : RESYNC ? ST_SYNC
                  : (state == ST_TRACK && sample_ok && !hold && !inc) ? ST_ERROR
                  : state;
    end

    // State register plus registered outputs; valid and error flags follow the state being entered.
    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state       <= ST_SYNC;
            COUNT_OUT   <= '0;
            COUNT_VALID <= 1'b0;
            WRAP        <= 1'b0;
            WRAPS       <= '0;
            MATCH       <= 1'b0;
            SEQ_ERR     <= 1'b0;
        end else begin
            state       <= nxt;
            COUNT_OUT   <= load ? sample : COUNT_OUT;
            COUNT_VALID <= nxt != ST_SYNC;
            WRAP        <= wrap_d;
            WRAPS       <= WRAPS + WRAP_W'(wrap_d);
            MATCH       <= match_d;
            SEQ_ERR     <= nxt == ST_ERROR;
        end
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Consumes the 4-bit ripple count Q from the counter stage and samples it on the rising edge of CLOCK; the ripple counter toggles on the opposite edge.
- Checks that successive samples step by +1 or hold, and flags any other change as a sequence error.
- Counts wrap-arounds into a wider extension register and pulses on a programmable compare value.
- Sits directly downstream of the counter and gives the rest of the design a clean, checked count plus events.

Parameters:
- WIDTH, 4, width of Q_IN / COUNT_OUT / CMP
- WRAP_W, 8, width of the wrap-extension counter WRAPS

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge
- CLEAR  input  1  asynchronous, active-high reset
- Q_IN  input  WIDTH  count from the upstream ripple counter
- CMP  input  WIDTH  compare value for MATCH
- ARM  input  1  enables MATCH generation
- RESYNC  input  1  synchronous request to return to SYNC
- COUNT_OUT  output  WIDTH  last accepted count
- COUNT_VALID  output  1  high once a count has been accepted since SYNC
- WRAP  output  1  one-cycle pulse on accepted max->0 step
- WRAPS  output  WRAP_W  number of wraps since reset, modulo 2^WRAP_W
- MATCH  output  1  one-cycle pulse on accepted change to CMP while ARM=1
- SEQ_ERR  output  1  sticky sequence-error flag
- STATE  output  2  FSM state: 0=SYNC, 1=TRACK, 2=ERROR

Behaviour:
- Reset: CLEAR high forces the following immediately, independent of CLOCK:
  - COUNT_OUT=0, COUNT_VALID=0, WRAP=0, WRAPS=0, MATCH=0, SEQ_ERR=0, STATE=SYNC.
  - Reset mid-operation discards all history.
- Accepted value "new": Q_IN sampled at a rising edge. Latency is 1 edge without the filter. "prev" is the current COUNT_OUT.
- SYNC, at each edge with CLEAR low:
  - COUNT_OUT<=new, COUNT_VALID<=1, go to TRACK.
  - No WRAP, MATCH or error check on this edge.
- TRACK, at each edge:
  - new==prev: hold; no events.
  - new==prev+1 mod 2^WIDTH: COUNT_OUT<=new.
    - If prev==2^WIDTH-1 (so new==0): WRAP=1 for one cycle, WRAPS<=WRAPS+1 (wraps silently).
  - Any other value: COUNT_OUT<=new, SEQ_ERR<=1, go to ERROR; no WRAP or MATCH on that edge.
  - MATCH=1 for one cycle when new!=prev, the step is legal, new==CMP and ARM==1.
  - WRAP and MATCH may pulse on the same edge when CMP==0.
- ERROR:
  - COUNT_OUT keeps following Q_IN.
  - WRAP, MATCH and WRAPS are frozen at 0 / unchanged.
  - SEQ_ERR stays 1.
- RESYNC=1 at an edge in TRACK or ERROR:
  - Next state is SYNC, COUNT_VALID<=0, SEQ_ERR<=0.
  - COUNT_OUT and WRAPS are retained.
  - The step check on that edge is suppressed.
- RESYNC in SYNC: ignored; the normal SYNC capture happens.
- Priority: CLEAR > RESYNC > step evaluation.
- Pulses WRAP and MATCH are registered and never last more than one cycle.

Optional Feature:
- Macro: COUNT_MONITOR_GLITCH_FILTER_EN.
- When defined:
  - Q_IN is double-sampled.
  - A value counts as "new" only when two consecutive samples agree; otherwise it is treated as hold.
  - Latency from a Q_IN change to COUNT_OUT becomes 2 edges.
  - SYNC waits for the first agreeing pair before leaving.
- When undefined: single sample, latency 1, every sample is acted on.

Decomposition:
- Package count_monitor_pkg holds:
  - state encodings ST_SYNC=2'd0, ST_TRACK=2'd1, ST_ERROR=2'd2;
  - default WIDTH/WRAP_W constants.
- Sub-module count_monitor_sampler:
  - holds the Q_IN capture and the optional glitch filter;
  - outputs the sample plus a sample_ok qualifier.
- The top module holds the FSM, compare logic and WRAPS.

Test Plan:
- Reset: CLEAR=1 for 34 time units with CLOCK period 20 → all outputs 0 and STATE=0 during reset; first edge after release gives COUNT_VALID=1, STATE=1.
- Free-running count 0..15..0..3 → COUNT_OUT tracks with 1-edge lag; single WRAP pulse at the 15→0 acceptance; WRAPS=1; SEQ_ERR=0.
- CMP=5, ARM=1 → exactly one MATCH pulse when COUNT_OUT becomes 5; with ARM=0 → no MATCH. CMP=0 → WRAP and MATCH in the same cycle.
- Q_IN jump 3→9 → SEQ_ERR=1, STATE=2, no MATCH even if CMP=9. Then RESYNC pulse → STATE=0 then 1, SEQ_ERR=0, WRAPS unchanged.
- CLEAR asserted mid-count (Q_IN=7, WRAPS=2) → immediate zeroing regardless of CLOCK; after release, capture restarts from the current Q_IN.
- With COUNT_MONITOR_GLITCH_FILTER_EN, a one-cycle Q_IN glitch 4→12→5 → no SEQ_ERR; COUNT_OUT shows 4 then 5 with 2-edge latency.
